// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   - owner_e : which requester owns the read data returning next cycle
//   - DEF_WAIT_MAX / DEF_IO_BIT : default starvation bound and IO select bit
//   - WAIT_CW / STAT_W : starvation counter and statistics counter widths
//   - sat_inc : saturating increment for the statistics counters
package dmem_arb_pkg;

  localparam int unsigned DEF_WAIT_MAX = 4;
  localparam int unsigned DEF_IO_BIT   = 7;
  localparam int unsigned WAIT_CW      = 4;
  localparam int unsigned STAT_W       = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports and the datamem/IO side of the arbiter.
//   Port A / port B : req, we, addr, wdata in; gnt, rvalid, rdata out
//                     (stall_a for A only, err_b for B only)
//   Memory side     : mem_addr, mem_datain, mem_we out; mem_dataout in
//   slave  modport  : arbiter view
//   master modport  : requesters + memory view (used by the bench)
interface dmem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          req_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a;
  logic          gnt_a;
  logic          stall_a;
  logic          rvalid_a;
  logic [DW-1:0] rdata_a;

  logic          req_b;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;
  logic          gnt_b;
  logic          rvalid_b;
  logic [DW-1:0] rdata_b;
  logic          err_b;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_datain;
  logic          mem_we;
  logic [DW-1:0] mem_dataout;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  mem_dataout,
    output gnt_a, stall_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b, err_b,
    output mem_addr, mem_datain, mem_we
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output mem_dataout,
    input  gnt_a, stall_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b, err_b,
    input  mem_addr, mem_datain, mem_we
  );

endinterface

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating starvation counter for one low-priority requester.
//   clock, reset : clock and async active-high reset
//   i_req        : requester is asking this cycle
//   i_gnt        : requester was granted this cycle
//   o_force_c    : counter has reached WAIT_MAX, requester must win next
module dmem_arb_wait_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned WAIT_MAX = DEF_WAIT_MAX
) (
  input  logic clock,
  input  logic reset,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_force_c
);

  localparam logic [WAIT_CW-1:0] LP_MAX = WAIT_CW'(WAIT_MAX);

  logic [WAIT_CW-1:0] r_cnt;

  // Count refused cycles; any grant or a dropped request restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != LP_MAX) begin
      r_cnt <= r_cnt + WAIT_CW'(1);
    end
  end

  assign o_force_c = (r_cnt == LP_MAX);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the datamem/IO block.
//   clock, reset : clock and async active-high reset
//   bus          : slave modport; port A (CPU MEM stage, priority),
//                  port B (loader/DMA, starvation-bounded) and memory side
//   conflict_cnt : cycles with both ports requesting (optional, saturating)
//   force_cnt    : B grants won through the starvation bound (optional)
// Optional statistics are built when DMEM_ARB_STATS_EN is defined.
// gnt/stall/mem_* are combinational from requests and registered state;
// rvalid/err come from registers, rdata passes the memory's registered
// dataout to the owning port and otherwise holds its last value.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned WAIT_MAX = DEF_WAIT_MAX,
  parameter int unsigned IO_BIT   = DEF_IO_BIT
) (
  input  logic clock,
  input  logic reset,
  dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] conflict_cnt,
  output logic [STAT_W-1:0] force_cnt
`endif
);

  logic          w_req_a;
  logic          w_req_b;
  logic          w_force_b;
  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          w_b_io_wr;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_datain;
  logic          w_mem_we;

  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_datain;
  logic [DW-1:0] r_rdata_a;
  logic [DW-1:0] r_rdata_b;
  logic          r_err_b;
  owner_e        r_own;
  owner_e        w_own_nxt;

  // Requests are masked while reset is held so every output reads 0.
  assign w_req_a = bus.req_a & ~reset;
  assign w_req_b = bus.req_b & ~reset;

  dmem_arb_wait_ctr #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_b (
    .clock     (clock),
    .reset     (reset),
    .i_req     (w_req_b),
    .i_gnt     (w_gnt_b),
    .o_force_c (w_force_b)
  );

  // A wins unless B has been refused WAIT_MAX times in a row.
  assign w_gnt_b   = w_req_b & (~w_req_a | w_force_b);
  assign w_gnt_a   = w_req_a & ~w_gnt_b;
  assign w_b_io_wr = bus.we_b & bus.addr_b[IO_BIT];

  assign bus.gnt_a   = w_gnt_a;
  assign bus.gnt_b   = w_gnt_b;
  assign bus.stall_a = w_req_a & ~w_gnt_a;

  // Memory-side mux; idle cycles replay the last address/data.
  always_comb begin
    w_mem_addr   = r_mem_addr;
    w_mem_datain = r_mem_datain;
    w_mem_we     = 1'b0;
    if (w_gnt_a) begin
      w_mem_addr   = bus.addr_a;
      w_mem_datain = bus.wdata_a;
      w_mem_we     = bus.we_a;
    end else if (w_gnt_b) begin
      w_mem_addr   = bus.addr_b;
      w_mem_datain = bus.wdata_b;
      w_mem_we     = bus.we_b & ~w_b_io_wr;
    end
  end

  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_datain = w_mem_datain;
  assign bus.mem_we     = w_mem_we;

  // Hold registers for the memory address/data bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_addr   <= '0;
      r_mem_datain <= '0;
    end else begin
      r_mem_addr   <= w_mem_addr;
      r_mem_datain <= w_mem_datain;
    end
  end

  // Read-owner state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_own <= OWN_NONE;
    end else begin
      r_own <= w_own_nxt;
    end
  end

  // Next owner follows this cycle's granted read; writes and idle give NONE.
  always_comb begin
    w_own_nxt = OWN_NONE;
    if (w_gnt_a && !bus.we_a) begin
      w_own_nxt = OWN_A;
    end else if (w_gnt_b && !bus.we_b) begin
      w_own_nxt = OWN_B;
    end
  end

  // Capture returned data so a port keeps showing its last read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      if (r_own == OWN_A) r_rdata_a <= bus.mem_dataout;
      if (r_own == OWN_B) r_rdata_b <= bus.mem_dataout;
    end
  end

  assign bus.rvalid_a = (r_own == OWN_A);
  assign bus.rvalid_b = (r_own == OWN_B);
  assign bus.rdata_a  = (r_own == OWN_A) ? bus.mem_dataout : r_rdata_a;
  assign bus.rdata_b  = (r_own == OWN_B) ? bus.mem_dataout : r_rdata_b;

  // One-cycle error pulse after a blocked IO write from B.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_b <= 1'b0;
    end else begin
      r_err_b <= w_gnt_b & w_b_io_wr;
    end
  end

  assign bus.err_b = r_err_b;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] r_conflict_cnt;
  logic [STAT_W-1:0] r_force_cnt;

  // A B grant while A also requests can only come from the starvation bound.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_conflict_cnt <= '0;
      r_force_cnt    <= '0;
    end else begin
      if (w_req_a & w_req_b) r_conflict_cnt <= sat_inc(r_conflict_cnt);
      if (w_gnt_b & w_req_a) r_force_cnt    <= sat_inc(r_force_cnt);
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign force_cnt    = r_force_cnt;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model with its own memory image.
module tb_dmem_port_arbiter;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned WAIT_MAX = 4;
  localparam int unsigned IO_BIT   = 7;

  logic clock = 1'b0;
  logic reset;
  logic mem_fill;

  int errors = 0;
  int checks = 0;

  dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [15:0] force_cnt;
`endif

  dmem_port_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .WAIT_MAX (WAIT_MAX),
    .IO_BIT   (IO_BIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .force_cnt    (force_cnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // Datamem stand-in: registered read, write on mem_we.
  logic [DW-1:0] tb_mem [64];
  always @(posedge clock) begin
    if (mem_fill) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
    end else if (bus.mem_we) begin
      tb_mem[bus.mem_addr[7:2]] <= bus.mem_datain;
    end
    bus.mem_dataout <= tb_mem[bus.mem_addr[7:2]];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [64];
  int            m_wait;
  int            m_pend_own;   // 0 none, 1 A, 2 B: who sees data this cycle
  logic [DW-1:0] m_rdata_a, m_rdata_b;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic          m_err;
  int            m_conf, m_forc;
  // Expected combinational outputs for the current cycle.
  logic          e_gnt_a, e_gnt_b, e_stall, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;

  task automatic model_reset();
    m_wait = 0; m_pend_own = 0; m_rdata_a = '0; m_rdata_b = '0;
    m_addr = '0; m_din = '0; m_err = 1'b0; m_conf = 0; m_forc = 0;
  endtask

  task automatic model_eval();
    logic force_b;
    force_b = (m_wait == int'(WAIT_MAX));
    e_gnt_b = bus.req_b && (!bus.req_a || force_b);
    e_gnt_a = bus.req_a && !e_gnt_b;
    e_stall = bus.req_a && !e_gnt_a;
    e_addr = m_addr; e_din = m_din; e_we = 1'b0;
    if (e_gnt_a) begin
      e_addr = bus.addr_a; e_din = bus.wdata_a; e_we = bus.we_a;
    end else if (e_gnt_b) begin
      e_addr = bus.addr_b; e_din = bus.wdata_b;
      e_we = bus.we_b && !bus.addr_b[IO_BIT];
    end
  endtask

  task automatic model_commit();
    int            rd_own;
    logic [DW-1:0] rd_data;
    rd_own = 0; rd_data = '0;
    if (e_gnt_a && !bus.we_a) begin
      rd_own = 1; rd_data = ref_mem[bus.addr_a[7:2]];
    end else if (e_gnt_b && !bus.we_b) begin
      rd_own = 2; rd_data = ref_mem[bus.addr_b[7:2]];
    end
    if (e_we) ref_mem[e_addr[7:2]] = e_din;
    m_pend_own = rd_own;
    if (rd_own == 1) m_rdata_a = rd_data;
    if (rd_own == 2) m_rdata_b = rd_data;
    m_err = e_gnt_b && bus.we_b && bus.addr_b[IO_BIT];
    if (bus.req_a && bus.req_b && m_conf < 65535) m_conf++;
    if (e_gnt_b && bus.req_a && m_forc < 65535) m_forc++;
    if (!bus.req_b || e_gnt_b) m_wait = 0;
    else if (m_wait < int'(WAIT_MAX)) m_wait++;
    m_addr = e_addr; m_din = e_din;
  endtask

  task automatic drive(input logic ra, input logic wa, input logic [AW-1:0] aa,
                       input logic [DW-1:0] da, input logic rb, input logic wb,
                       input logic [AW-1:0] ab, input logic [DW-1:0] db);
    bus.req_a = ra; bus.we_a = wa; bus.addr_a = aa; bus.wdata_a = da;
    bus.req_b = rb; bus.we_b = wb; bus.addr_b = ab; bus.wdata_b = db;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Inputs change at posedge+1; settle lands mid-cycle, advance crosses an edge.
  task automatic settle();
    #4;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 32'h44, 32'h1234, 1'b1, 1'b1, 32'h48, 32'h5678);
    #2;
    checks++; if (bus.gnt_a !== 1'b0) begin errors++; $display("FAIL rst_gnt_a: got %b exp 0", bus.gnt_a); end
    checks++; if (bus.gnt_b !== 1'b0) begin errors++; $display("FAIL rst_gnt_b: got %b exp 0", bus.gnt_b); end
    checks++; if (bus.stall_a !== 1'b0) begin errors++; $display("FAIL rst_stall_a: got %b exp 0", bus.stall_a); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b exp 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h exp 0", bus.mem_addr); end
    checks++; if (bus.mem_datain !== 32'h0) begin errors++; $display("FAIL rst_mem_datain: got %h exp 0", bus.mem_datain); end
    checks++; if (bus.rvalid_a !== 1'b0 || bus.rvalid_b !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b exp 00", bus.rvalid_a, bus.rvalid_b); end
    checks++; if (bus.rdata_a !== 32'h0 || bus.rdata_b !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h %h exp 0 0", bus.rdata_a, bus.rdata_b); end
    checks++; if (bus.err_b !== 1'b0) begin errors++; $display("FAIL rst_err_b: got %b exp 0", bus.err_b); end
`ifdef DMEM_ARB_STATS_EN
    checks++; if (conflict_cnt !== 16'd0 || force_cnt !== 16'd0) begin errors++; $display("FAIL rst_stats: got %0d %0d exp 0 0", conflict_cnt, force_cnt); end
`endif
    idle();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_a_read();
    drive(1'b1, 1'b1, 32'h04, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    settle();
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL a_wr_we: got %b exp 1", bus.mem_we); end
    advance();
    drive(1'b1, 1'b0, 32'h04, '0, 1'b0, 1'b0, '0, '0);
    settle();
    checks++; if (bus.gnt_a !== 1'b1) begin errors++; $display("FAIL a_rd_gnt: got %b exp 1", bus.gnt_a); end
    checks++; if (bus.stall_a !== 1'b0) begin errors++; $display("FAIL a_rd_stall: got %b exp 0", bus.stall_a); end
    checks++; if (bus.mem_addr !== 32'h04 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL a_rd_bus: got %h/%b exp 00000004/0", bus.mem_addr, bus.mem_we); end
    advance();
    idle();
    settle();
    checks++; if (bus.rvalid_a !== 1'b1) begin errors++; $display("FAIL a_rd_rvalid: got %b exp 1", bus.rvalid_a); end
    checks++; if (bus.rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL a_rd_rdata: got %h exp deadbeef", bus.rdata_a); end
    checks++; if (bus.rvalid_b !== 1'b0) begin errors++; $display("FAIL a_rd_rvalid_b: got %b exp 0", bus.rvalid_b); end
    advance();
  endtask

  task automatic test_reset_mid_read();
    drive(1'b1, 1'b0, 32'h10, '0, 1'b0, 1'b0, '0, '0);
    settle();
    checks++; if (bus.gnt_a !== 1'b1) begin errors++; $display("FAIL mid_gnt: got %b exp 1", bus.gnt_a); end
    reset = 1'b1;
    #1;
    model_reset();
    checks++; if (bus.gnt_a !== 1'b0 || bus.stall_a !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ctl: got gnt=%b stall=%b we=%b exp 000", bus.gnt_a, bus.stall_a, bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_addr: got %h exp 0", bus.mem_addr); end
    @(posedge clock);
    #1;
    idle();
    reset = 1'b0;
    settle();
    checks++; if (bus.rvalid_a !== 1'b0) begin errors++; $display("FAIL mid_no_rvalid: got %b exp 0", bus.rvalid_a); end
    checks++; if (bus.rdata_a !== 32'h0) begin errors++; $display("FAIL mid_rdata: got %h exp 0", bus.rdata_a); end
    advance();
  endtask

  task automatic test_starvation();
    logic exp_b;
    do_reset();
    drive(1'b1, 1'b0, 32'h20, '0, 1'b1, 1'b0, 32'h24, '0);
    for (int i = 0; i < 10; i++) begin
      settle();
      exp_b = (i % 5 == 4);
      checks++; if (bus.gnt_b !== exp_b) begin errors++; $display("FAIL starve_gnt_b[%0d]: got %b exp %b", i, bus.gnt_b, exp_b); end
      checks++; if (bus.gnt_a !== !exp_b) begin errors++; $display("FAIL starve_gnt_a[%0d]: got %b exp %b", i, bus.gnt_a, !exp_b); end
      checks++; if (bus.stall_a !== exp_b) begin errors++; $display("FAIL starve_stall[%0d]: got %b exp %b", i, bus.stall_a, exp_b); end
      advance();
    end
    idle();
    settle();
`ifdef DMEM_ARB_STATS_EN
    checks++; if (conflict_cnt !== 16'd10) begin errors++; $display("FAIL stats_conflict: got %0d exp 10", conflict_cnt); end
    checks++; if (force_cnt !== 16'd2) begin errors++; $display("FAIL stats_force: got %0d exp 2", force_cnt); end
`endif
    advance();
  endtask

  task automatic test_interleave();
    logic [DW-1:0] exp_a, exp_b;
    exp_a = ref_mem[2];
    exp_b = ref_mem[3];
    drive(1'b1, 1'b0, 32'h08, '0, 1'b0, 1'b0, '0, '0);
    settle();
    checks++; if (bus.gnt_a !== 1'b1) begin errors++; $display("FAIL il_gnt_a: got %b exp 1", bus.gnt_a); end
    advance();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0C, '0);
    settle();
    checks++; if (bus.gnt_b !== 1'b1) begin errors++; $display("FAIL il_gnt_b: got %b exp 1", bus.gnt_b); end
    checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== exp_a) begin errors++; $display("FAIL il_a_ret: got %b/%h exp 1/%h", bus.rvalid_a, bus.rdata_a, exp_a); end
    checks++; if (bus.rvalid_b !== 1'b0) begin errors++; $display("FAIL il_b_early: got %b exp 0", bus.rvalid_b); end
    advance();
    idle();
    settle();
    checks++; if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== exp_b) begin errors++; $display("FAIL il_b_ret: got %b/%h exp 1/%h", bus.rvalid_b, bus.rdata_b, exp_b); end
    checks++; if (bus.rvalid_a !== 1'b0 || bus.rdata_a !== exp_a) begin errors++; $display("FAIL il_a_hold: got %b/%h exp 0/%h", bus.rvalid_a, bus.rdata_a, exp_a); end
    advance();
  endtask

  task automatic test_io_protect();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h80, 32'h55);
    settle();
    checks++; if (bus.gnt_b !== 1'b1) begin errors++; $display("FAIL io_gnt_b: got %b exp 1", bus.gnt_b); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL io_b_we: got %b exp 0", bus.mem_we); end
    advance();
    drive(1'b1, 1'b0, 32'h80, '0, 1'b0, 1'b0, '0, '0);
    settle();
    checks++; if (bus.err_b !== 1'b1) begin errors++; $display("FAIL io_err: got %b exp 1", bus.err_b); end
    advance();
    drive(1'b1, 1'b1, 32'h80, 32'h55, 1'b0, 1'b0, '0, '0);
    settle();
    checks++; if (bus.rdata_a !== init_word(32)) begin errors++; $display("FAIL io_unwritten: got %h exp %h", bus.rdata_a, init_word(32)); end
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_datain !== 32'h55) begin errors++; $display("FAIL io_a_we: got %b/%h exp 1/00000055", bus.mem_we, bus.mem_datain); end
    checks++; if (bus.err_b !== 1'b0) begin errors++; $display("FAIL io_err_pulse: got %b exp 0", bus.err_b); end
    advance();
    idle();
    settle();
    checks++; if (bus.err_b !== 1'b0) begin errors++; $display("FAIL io_err_a: got %b exp 0", bus.err_b); end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)) << 2, $urandom,
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)) << 2, $urandom);
      settle();
      checks++; if (bus.gnt_a !== e_gnt_a || bus.gnt_b !== e_gnt_b) begin
        errors++; $display("FAIL rnd_gnt[%0d]: got %b%b exp %b%b", n, bus.gnt_a, bus.gnt_b, e_gnt_a, e_gnt_b); end
      checks++; if (bus.stall_a !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %b exp %b", n, bus.stall_a, e_stall); end
      checks++; if (bus.mem_we !== e_we || bus.mem_addr !== e_addr || bus.mem_datain !== e_din) begin
        errors++; $display("FAIL rnd_mem[%0d]: got %b/%h/%h exp %b/%h/%h", n, bus.mem_we, bus.mem_addr, bus.mem_datain, e_we, e_addr, e_din); end
      checks++; if (bus.rvalid_a !== (m_pend_own == 1) || bus.rvalid_b !== (m_pend_own == 2)) begin
        errors++; $display("FAIL rnd_rvalid[%0d]: got %b%b exp owner %0d", n, bus.rvalid_a, bus.rvalid_b, m_pend_own); end
      checks++; if (bus.rdata_a !== m_rdata_a || bus.rdata_b !== m_rdata_b) begin
        errors++; $display("FAIL rnd_rdata[%0d]: got %h %h exp %h %h", n, bus.rdata_a, bus.rdata_b, m_rdata_a, m_rdata_b); end
      checks++; if (bus.err_b !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b exp %b", n, bus.err_b, m_err); end
`ifdef DMEM_ARB_STATS_EN
      checks++; if (conflict_cnt !== 16'(m_conf) || force_cnt !== 16'(m_forc)) begin
        errors++; $display("FAIL rnd_stats[%0d]: got %0d %0d exp %0d %0d", n, conflict_cnt, force_cnt, m_conf, m_forc); end
`endif
      advance();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    mem_fill = 1'b1;
    idle();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    mem_fill = 1'b0;
    test_reset();
    test_a_read();
    test_reset_mid_read();
    test_starvation();
    test_interleave();
    test_io_protect();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory/IO space between two requesters: port A (pipeline CPU MEM stage) and port B (loader/DMA).
- Sits in front of the datamem/IO block and drives its addr/datain/we.
- Returns its registered dataout to the requester that owns each read.
- Port A has priority; port B waits at most WAIT_MAX cycles (starvation bound); a stall output freezes the CPU pipeline while A is blocked.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT_MAX, 4, max consecutive cycles B may be refused while requesting (1..15).
- IO_BIT, 7, address bit selecting IO space (1 = IO).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_a  in  1  port A access request.
- we_a  in  1  port A write enable.
- addr_a  in  AW  port A byte address.
- wdata_a  in  DW  port A write data.
- gnt_a  out  1  port A access accepted this cycle.
- stall_a  out  1  req_a & ~gnt_a (pipeline freeze).
- rvalid_a  out  1  port A read data valid.
- rdata_a  out  DW  port A read data.
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as A for port B.
- err_b  out  1  pulse: B attempted IO write (blocked).
- mem_addr  out  AW  to datamem addr.
- mem_datain  out  DW  to datamem datain.
- mem_we  out  1  to datamem we.
- mem_dataout  in  DW  from datamem dataout, valid one cycle after address.

Behaviour:
- Grant (combinational, same cycle):
  - gnt_b = req_b & (~req_a | force_b).
  - gnt_a = req_a & ~gnt_b.
  - At most one grant per cycle; every cycle can carry an access.
- force_b = (wait_cnt == WAIT_MAX).
- wait_cnt (4-bit register):
  - Cleared on reset or gnt_b.
  - Incremented when req_b & ~gnt_b; saturates at WAIT_MAX.
  - Cleared when req_b drops.
- Mux: mem_addr/mem_datain/mem_we come from the granted port.
  - No grant: mem_we = 0; addr/datain hold their last value (registered hold, no glitching to 0).
- IO protection: B write with addr_b[IO_BIT] = 1:
  - Granted normally (gnt_b = 1), but mem_we forced to 0.
  - err_b = 1 the following cycle for one cycle.
  - Port A may write IO.
- Read return:
  - Granted read (we = 0) sets owner register rd_own ∈ {NONE, A, B} for next cycle.
  - Next cycle: rvalid_x = 1 for the owner, rdata_x = mem_dataout. Non-owner rdata holds its previous value.
  - Writes produce no rvalid.
- Owner FSM (2-bit state, NONE/A/B): state updates every edge from the current grant; back-to-back reads alternate cleanly (A read at t, B read at t+1 → rvalid_a at t+1, rvalid_b at t+2).
- Simultaneous req_a & req_b with force_b = 0 → A wins; B wait_cnt++.
- A and B writing same address in consecutive cycles: order = grant order; no merging.
- Reset (any time, including mid-read):
  - gnt/stall/rvalid/err/mem_we = 0; rdata_a/b = 0.
  - mem_addr/mem_datain = 0; wait_cnt = 0; rd_own = NONE.
  - A pending read is dropped (no rvalid after reset release).
- Outputs rvalid/rdata/err are registered; gnt/stall/mem_* are combinational from requests plus registered state.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Adds outputs conflict_cnt (16-bit): cycles with req_a & req_b, saturating at 0xFFFF.
  - Adds force_cnt (16-bit): grants caused by force_b, saturating at 0xFFFF.
  - Both reset to 0.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_arb_pkg:
  - owner enum (OWN_NONE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2).
  - WAIT_MAX default.
  - IO_BIT default.
- One natural sub-module: dmem_arb_wait_ctr (saturating starvation counter producing force_b), reusable for further requesters.

Test Plan:
- Reset mid-read: A read addr 0x10 granted, reset asserted same cycle → no rvalid_a after release; all outputs 0.
- A-only read: A read 0x04, datamem returns 0xDEADBEEF → gnt_a = 1 at t; rvalid_a = 1, rdata_a = 0xDEADBEEF at t+1; stall_a = 0.
- Starvation: req_a and req_b held high, WAIT_MAX = 4 → B refused for 4 cycles, gnt_b = 1 on the 5th cycle with stall_a = 1 that cycle, then A resumes; wait_cnt returns to 0.
- Interleaved reads: A read 0x08 at t, B read 0x0C at t+1 → rvalid_a at t+1 with mem[0x08], rvalid_b at t+2 with mem[0x0C]; no cross-delivery.
- IO protection: B write 0x80 data 0x55 → gnt_b = 1, mem_we = 0, err_b = 1 at t+1; A write 0x80 data 0x55 → mem_we = 1, err_b = 0.
- Stats (DMEM_ARB_STATS_EN): 10 cycles of dual request with WAIT_MAX = 4 → conflict_cnt = 10, force_cnt = 2.
